// File: rtl/os_array_ctrl.sv
// Job sequencer for an N x N output-stationary systolic MAC array: clear, skewed
// compute feed, then row-by-row result drain over a valid/ready handshake.
module os_array_ctrl #(
    parameter int unsigned N   = 4,
    parameter int unsigned K_W = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start_i,
    input  logic [K_W-1:0]         k_len_i,
    input  logic                   stall_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   arr_clr_o,
    output logic                   acc_en_o,
    output logic [N-1:0]           row_feed_en_o,
    output logic [N-1:0]           col_feed_en_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [$clog2(N)-1:0]   out_row_o,
    output logic                   out_last_o
);

    localparam int unsigned CNT_W = K_W + $clog2(2 * N) + 1;
    localparam int unsigned RS_W  = $clog2(N);

    localparam logic [CNT_W-1:0] FILL_FLUSH = CNT_W'(2 * N - 3);
    localparam logic [RS_W-1:0]  ROW_LAST   = RS_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [K_W-1:0]   k_q;
    logic [CNT_W-1:0] c_q;
    logic [RS_W-1:0]  r_q;

    logic [CNT_W-1:0] k_ext;
    logic [CNT_W-1:0] c_last;
    logic             c_at_last;
    logic             r_at_last;
    logic             compute_go;
    logic             drain_hs;
    logic [N-1:0]     feed_win;

    assign k_ext      = CNT_W'(k_q);
    assign c_last     = k_ext + FILL_FLUSH;
    assign c_at_last  = (c_q == c_last);
    assign r_at_last  = (r_q == ROW_LAST);
    assign compute_go = (state_q == S_COMPUTE) && !stall_i;
    assign drain_hs   = (state_q == S_DRAIN) && out_ready_i;

    // Skew window: lane i carries operands on cycles i .. i+K-1, in full counter width.
    always_comb begin
        feed_win = '0;
        for (int unsigned i = 0; i < N; i++) begin
            feed_win[i] = (c_q >= CNT_W'(i)) && (c_q < (k_ext + CNT_W'(i)));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = (k_q == '0) ? S_DRAIN : S_COMPUTE;
            end
            S_COMPUTE: begin
                if (compute_go && c_at_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_hs && r_at_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_q <= '0;
        end else if ((state_q == S_IDLE) && start_i) begin
            k_q <= k_len_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_q <= '0;
        end else if (state_q != S_COMPUTE) begin
            c_q <= '0;
        end else if (compute_go) begin
            c_q <= c_at_last ? '0 : c_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q <= '0;
        end else if (state_q != S_DRAIN) begin
            r_q <= '0;
        end else if (drain_hs) begin
            r_q <= r_at_last ? '0 : r_q + 1'b1;
        end
    end

    always_comb begin
        busy_o        = (state_q != S_IDLE);
        done_o        = (state_q == S_DONE);
        arr_clr_o     = (state_q == S_CLEAR);
        acc_en_o      = compute_go;
        row_feed_en_o = compute_go ? feed_win : '0;
        col_feed_en_o = compute_go ? feed_win : '0;
        out_valid_o   = (state_q == S_DRAIN);
        out_row_o     = (state_q == S_DRAIN) ? r_q : '0;
        out_last_o    = (state_q == S_DRAIN) && r_at_last;
    end

endmodule

// File: tb/tb_os_array_ctrl.sv
// Directed bench for os_array_ctrl (N=4, K_W=8): job timing, stall, drain
// backpressure, K=0, mid-job reset and held start with K=255.
module tb_os_array_ctrl;

    logic       clk;
    logic       rstn;
    logic       start_i;
    logic [7:0] k_len_i;
    logic       stall_i;
    logic       busy_o;
    logic       done_o;
    logic       arr_clr_o;
    logic       acc_en_o;
    logic [3:0] row_feed_en_o;
    logic [3:0] col_feed_en_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [1:0] out_row_o;
    logic       out_last_o;

    int n_cmp;
    int n_err;

    os_array_ctrl #(.N(4), .K_W(8)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start_i       (start_i),
        .k_len_i       (k_len_i),
        .stall_i       (stall_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .arr_clr_o     (arr_clr_o),
        .acc_en_o      (acc_en_o),
        .row_feed_en_o (row_feed_en_o),
        .col_feed_en_o (col_feed_en_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_row_o     (out_row_o),
        .out_last_o    (out_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed K=3, N=4 feed pattern for c = 0..8 (rows and columns identical).
    logic [3:0] feed_tbl [0:8];
    initial begin
        feed_tbl[0] = 4'b0001; feed_tbl[1] = 4'b0011; feed_tbl[2] = 4'b0111;
        feed_tbl[3] = 4'b1110; feed_tbl[4] = 4'b1100; feed_tbl[5] = 4'b1000;
        feed_tbl[6] = 4'b0000; feed_tbl[7] = 4'b0000; feed_tbl[8] = 4'b0000;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start_i = 1'b0; k_len_i = '0; stall_i = 1'b0; out_ready_i = 1'b1;
        repeat (3) tick();
        #2;
        n_cmp++;
        if ({busy_o, done_o, arr_clr_o, acc_en_o, out_valid_o, out_last_o} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 000000",
                {busy_o, done_o, arr_clr_o, acc_en_o, out_valid_o, out_last_o});
        end
        n_cmp++;
        if ({row_feed_en_o, col_feed_en_o, out_row_o} !== 10'b0) begin
            n_err++; $display("FAIL reset_vec: got %b want 0", {row_feed_en_o, col_feed_en_o, out_row_o});
        end
        rstn = 1'b1;
        tick();
    endtask

    // K=3 job; optional stall at compute cycle stall_at, optional ready-low on drain row hold_row.
    task automatic test_k3_job(input string name, input int stall_at, input int stall_len,
                               input int hold_row, input int hold_len);
        int c;
        int stalled;
        int r;
        int held;
        int guard;
        start_i = 1'b1; k_len_i = 8'd3; stall_i = 1'b0; out_ready_i = 1'b1;
        #2;
        n_cmp++;
        if (busy_o !== 1'b0 || arr_clr_o !== 1'b0) begin
            n_err++; $display("FAIL %s idle: busy=%b clr=%b want 0 0", name, busy_o, arr_clr_o);
        end
        tick();
        start_i = 1'b0;
        #2;
        n_cmp++;
        if (arr_clr_o !== 1'b1 || busy_o !== 1'b1 || acc_en_o !== 1'b0) begin
            n_err++; $display("FAIL %s clear: clr=%b busy=%b acc=%b want 1 1 0", name, arr_clr_o, busy_o, acc_en_o);
        end
        tick();
        c = 0; stalled = 0; guard = 0;
        while (c < 9 && guard < 40) begin
            stall_i = (c == stall_at && stalled < stall_len);
            #2;
            n_cmp++;
            if (stall_i) begin
                if (acc_en_o !== 1'b0 || row_feed_en_o !== 4'b0 || col_feed_en_o !== 4'b0) begin
                    n_err++; $display("FAIL %s stall c=%0d: acc=%b row=%b col=%b want 0", name, c,
                        acc_en_o, row_feed_en_o, col_feed_en_o);
                end
            end else begin
                if (acc_en_o !== 1'b1 || row_feed_en_o !== feed_tbl[c] || col_feed_en_o !== feed_tbl[c]
                    || busy_o !== 1'b1 || out_valid_o !== 1'b0) begin
                    n_err++; $display("FAIL %s compute c=%0d: acc=%b row=%b col=%b valid=%b want 1 %b %b 0",
                        name, c, acc_en_o, row_feed_en_o, col_feed_en_o, out_valid_o, feed_tbl[c], feed_tbl[c]);
                end
            end
            tick();
            if (stall_i) stalled++; else c++;
            guard++;
        end
        stall_i = 1'b0;
        r = 0; held = 0; guard = 0;
        while (r < 4 && guard < 40) begin
            out_ready_i = !(r == hold_row && held < hold_len);
            #2;
            n_cmp++;
            if (out_valid_o !== 1'b1 || out_row_o !== 2'(r) || out_last_o !== (r == 3)
                || acc_en_o !== 1'b0 || done_o !== 1'b0) begin
                n_err++; $display("FAIL %s drain r=%0d: valid=%b row=%0d last=%b acc=%b done=%b", name, r,
                    out_valid_o, out_row_o, out_last_o, acc_en_o, done_o);
            end
            tick();
            if (out_ready_i) r++; else held++;
            guard++;
        end
        out_ready_i = 1'b1;
        #2;
        n_cmp++;
        if (done_o !== 1'b1 || busy_o !== 1'b1 || out_valid_o !== 1'b0) begin
            n_err++; $display("FAIL %s done: done=%b busy=%b valid=%b want 1 1 0", name, done_o, busy_o, out_valid_o);
        end
        tick();
        #2;
        n_cmp++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL %s idle_after: done=%b busy=%b want 0 0", name, done_o, busy_o);
        end
        tick();
    endtask

    task automatic test_k_zero();
        int acc_seen;
        start_i = 1'b1; k_len_i = 8'd0; out_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        #2;
        acc_seen = acc_en_o;
        n_cmp++;
        if (arr_clr_o !== 1'b1) begin
            n_err++; $display("FAIL k0_clear: clr=%b want 1", arr_clr_o);
        end
        tick();
        for (int r = 0; r < 4; r++) begin
            #2;
            if (acc_en_o !== 1'b0) acc_seen = 1;
            n_cmp++;
            if (out_valid_o !== 1'b1 || out_row_o !== 2'(r) || out_last_o !== (r == 3)) begin
                n_err++; $display("FAIL k0_drain r=%0d: valid=%b row=%0d last=%b", r, out_valid_o, out_row_o, out_last_o);
            end
            tick();
        end
        #2;
        n_cmp++;
        if (done_o !== 1'b1) begin
            n_err++; $display("FAIL k0_done: done=%b want 1", done_o);
        end
        n_cmp++;
        if (acc_seen !== 0) begin
            n_err++; $display("FAIL k0_acc_en: acc_en seen=%0d want 0", acc_seen);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_job();
        start_i = 1'b1; k_len_i = 8'd3;
        tick();
        start_i = 1'b0;
        tick();
        repeat (5) tick();
        #2;
        n_cmp++;
        if (acc_en_o !== 1'b1 || row_feed_en_o !== 4'b1000) begin
            n_err++; $display("FAIL rstmid_pre c=5: acc=%b row=%b want 1 1000", acc_en_o, row_feed_en_o);
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({busy_o, done_o, arr_clr_o, acc_en_o, out_valid_o, out_last_o, row_feed_en_o,
             col_feed_en_o, out_row_o} !== 16'b0) begin
            n_err++; $display("FAIL rstmid_outputs: busy=%b acc=%b row=%b col=%b want all 0",
                busy_o, acc_en_o, row_feed_en_o, col_feed_en_o);
        end
        tick();
        rstn = 1'b1;
        tick();
        test_k3_job("after_reset", -1, 0, -1, 0);
    endtask

    task automatic test_start_held();
        int n_acc;
        int guard;
        int n_done;
        start_i = 1'b1; k_len_i = 8'd255; out_ready_i = 1'b1;
        tick();
        k_len_i = 8'd5;
        #2;
        n_cmp++;
        if (arr_clr_o !== 1'b1) begin
            n_err++; $display("FAIL held_clear: clr=%b want 1", arr_clr_o);
        end
        tick();
        #2;
        n_acc = 0; guard = 0;
        while (acc_en_o === 1'b1 && guard < 400) begin
            n_acc++; guard++;
            tick();
            #2;
        end
        n_cmp++;
        if (n_acc !== 261) begin
            n_err++; $display("FAIL held_k255_len: compute cycles=%0d want 261", n_acc);
        end
        for (int r = 0; r < 4; r++) begin
            n_cmp++;
            if (out_valid_o !== 1'b1 || out_row_o !== 2'(r)) begin
                n_err++; $display("FAIL held_drain r=%0d: valid=%b row=%0d", r, out_valid_o, out_row_o);
            end
            tick();
            #2;
        end
        n_cmp++;
        if (done_o !== 1'b1) begin
            n_err++; $display("FAIL held_done: done=%b want 1", done_o);
        end
        tick();
        #2;
        n_cmp++;
        if (busy_o !== 1'b0 || arr_clr_o !== 1'b0) begin
            n_err++; $display("FAIL held_idle: busy=%b clr=%b want 0 0", busy_o, arr_clr_o);
        end
        tick();
        #2;
        n_cmp++;
        if (arr_clr_o !== 1'b1) begin
            n_err++; $display("FAIL held_restart: clr=%b want 1", arr_clr_o);
        end
        start_i = 1'b0;
        tick();
        n_acc = 0; n_done = 0; guard = 0;
        #2;
        while (busy_o === 1'b1 && guard < 100) begin
            if (acc_en_o === 1'b1) n_acc++;
            if (done_o === 1'b1) n_done++;
            guard++;
            tick();
            #2;
        end
        n_cmp++;
        if (guard >= 100 || n_done !== 1 || n_acc !== 11) begin
            n_err++; $display("FAIL held_second_job: cycles=%0d done=%0d acc=%0d want <100 1 11", guard, n_done, n_acc);
        end
        tick();
        #2;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++; $display("FAIL held_stays_idle: busy=%b want 0", busy_o);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_k3_job("basic", -1, 0, -1, 0);
        test_k3_job("stall", 4, 2, -1, 0);
        test_k3_job("drain_bp", -1, 0, 1, 3);
        test_k_zero();
        test_reset_mid_job();
        test_start_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
